// File: rtl/datapath_arbiter_if.sv
// datapath_arbiter_if: request, datapath-control and response signals of the CR16 datapath arbiter.
// Signal prefixes are from the arbiter's point of view.
interface datapath_arbiter_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REGS     = 16,
  parameter int SEL_WIDTH    = 4,
  parameter int OPCODE_WIDTH = 4,
  parameter int FLAGS_WIDTH  = 5
);
  logic [1:0]                carry_unused_guard;
  logic [1:0]                i_req_valid;
  logic [1:0]                o_req_ready;
  logic [2*OPCODE_WIDTH-1:0] i_req_opcode;
  logic [2*SEL_WIDTH-1:0]    i_req_rdest;
  logic [2*SEL_WIDTH-1:0]    i_req_rsrc;
  logic [2*DATA_WIDTH-1:0]   i_req_immediate;
  logic [1:0]                i_req_imm_sel;
  logic [1:0]                i_req_write;
  logic                      o_dp_nreset;
  logic [NUM_REGS-1:0]       o_dp_reg_write_enable;
  logic [SEL_WIDTH-1:0]      o_dp_reg_a_select;
  logic [SEL_WIDTH-1:0]      o_dp_reg_b_select;
  logic [DATA_WIDTH-1:0]     o_dp_immediate;
  logic                      o_dp_immediate_select;
  logic [OPCODE_WIDTH-1:0]   o_dp_opcode;
  logic [DATA_WIDTH-1:0]     i_dp_result;
  logic [FLAGS_WIDTH-1:0]    i_dp_status_flags;
  logic [1:0]                o_resp_valid;
  logic [DATA_WIDTH-1:0]     o_resp_data;
  logic [FLAGS_WIDTH-1:0]    o_resp_flags;
  logic                      o_busy;
  modport slave (
    input  i_req_valid, i_req_opcode, i_req_rdest, i_req_rsrc, i_req_immediate,
           i_req_imm_sel, i_req_write, i_dp_result, i_dp_status_flags,
    output o_req_ready, o_dp_nreset, o_dp_reg_write_enable, o_dp_reg_a_select,
           o_dp_reg_b_select, o_dp_immediate, o_dp_immediate_select, o_dp_opcode,
           o_resp_valid, o_resp_data, o_resp_flags, o_busy
  );
  modport master (
    output i_req_valid, i_req_opcode, i_req_rdest, i_req_rsrc, i_req_immediate,
           i_req_imm_sel, i_req_write, i_dp_result, i_dp_status_flags,
    input  o_req_ready, o_dp_nreset, o_dp_reg_write_enable, o_dp_reg_a_select,
           o_dp_reg_b_select, o_dp_immediate, o_dp_immediate_select, o_dp_opcode,
           o_resp_valid, o_resp_data, o_resp_flags, o_busy
  );
endinterface

// File: rtl/datapath_arbiter.sv
// datapath_arbiter: two-requester round-robin owner of the CR16 register file + ALU controls.
// One op per grant: accept in IDLE, drive controls for one EXEC cycle, pulse the response next cycle.
module datapath_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_REGS     = 16,
  parameter int SEL_WIDTH    = 4,
  parameter int OPCODE_WIDTH = 4,
  parameter int FLAGS_WIDTH  = 5
) (
  input logic                i_clk,
  input logic                i_nreset,
  datapath_arbiter_if.slave  bus
);
  localparam logic [1:0] S_INIT = 2'd0, S_IDLE = 2'd1, S_EXEC = 2'd2;
  logic [1:0]              r_state;
  logic                    r_ptr;
  logic                    r_id;
  logic                    r_dp_nreset;
  logic [NUM_REGS-1:0]     r_we;
  logic [SEL_WIDTH-1:0]    r_a_sel;
  logic [SEL_WIDTH-1:0]    r_b_sel;
  logic [DATA_WIDTH-1:0]   r_imm;
  logic                    r_imm_sel;
  logic [OPCODE_WIDTH-1:0] r_op;
  logic [1:0]              r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_data;
  logic [FLAGS_WIDTH-1:0]  r_resp_flags;
  logic [1:0]              w_grant;
  logic                    w_id;
  logic [OPCODE_WIDTH-1:0] w_op;
  logic [SEL_WIDTH-1:0]    w_rd;
  logic [SEL_WIDTH-1:0]    w_rs;
  logic [DATA_WIDTH-1:0]   w_imm;
  logic                    w_imm_sel;
  logic                    w_wr;
  // Contention goes to the pointer; a lone valid wins regardless of it.
  always_comb begin
    w_grant   = r_state != S_IDLE ? 2'b00 : &bus.i_req_valid ? (r_ptr ? 2'b10 : 2'b01) : bus.i_req_valid;
    w_id      = w_grant[1];
    w_op      = w_id ? bus.i_req_opcode[2*OPCODE_WIDTH-1:OPCODE_WIDTH] : bus.i_req_opcode[OPCODE_WIDTH-1:0];
    w_rd      = w_id ? bus.i_req_rdest[2*SEL_WIDTH-1:SEL_WIDTH] : bus.i_req_rdest[SEL_WIDTH-1:0];
    w_rs      = w_id ? bus.i_req_rsrc[2*SEL_WIDTH-1:SEL_WIDTH] : bus.i_req_rsrc[SEL_WIDTH-1:0];
    w_imm     = w_id ? bus.i_req_immediate[2*DATA_WIDTH-1:DATA_WIDTH] : bus.i_req_immediate[DATA_WIDTH-1:0];
    w_imm_sel = bus.i_req_imm_sel[w_id];
    w_wr      = bus.i_req_write[w_id];
  end
  // Control fields load at accept so they are registered during EXEC and hold afterwards.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state      <= S_INIT;
      r_ptr        <= 1'b0;
      r_id         <= 1'b0;
      r_dp_nreset  <= 1'b0;
      r_we         <= '0;
      r_a_sel      <= '0;
      r_b_sel      <= '0;
      r_imm        <= '0;
      r_imm_sel    <= 1'b0;
      r_op         <= '0;
      r_resp_valid <= 2'b00;
      r_resp_data  <= '0;
      r_resp_flags <= '0;
    end else begin
      r_resp_valid <= 2'b00;
      if (r_state == S_INIT) begin
        r_state     <= S_IDLE;
        r_dp_nreset <= 1'b1;
      end else if (r_state == S_EXEC) begin
        r_state      <= S_IDLE;
        r_we         <= '0;
        r_resp_data  <= bus.i_dp_result;
        r_resp_flags <= bus.i_dp_status_flags;
        r_resp_valid <= r_id ? 2'b10 : 2'b01;
      end else if (|w_grant) begin
        r_state   <= S_EXEC;
        r_id      <= w_id;
        r_ptr     <= ~w_id;
        r_a_sel   <= w_rd;
        r_b_sel   <= w_rs;
        r_imm     <= w_imm;
        r_imm_sel <= w_imm_sel;
        r_op      <= w_op;
        r_we      <= w_wr ? NUM_REGS'(1) << w_rd : '0;
      end
    end
  end
  assign bus.o_req_ready           = w_grant;
  assign bus.o_dp_nreset           = r_dp_nreset;
  assign bus.o_dp_reg_write_enable = r_we;
  assign bus.o_dp_reg_a_select     = r_a_sel;
  assign bus.o_dp_reg_b_select     = r_b_sel;
  assign bus.o_dp_immediate        = r_imm;
  assign bus.o_dp_immediate_select = r_imm_sel;
  assign bus.o_dp_opcode           = r_op;
  assign bus.o_resp_valid          = r_resp_valid;
  assign bus.o_resp_data           = r_resp_data;
  assign bus.o_resp_flags          = r_resp_flags;
  assign bus.o_busy                = i_nreset & (r_state != S_IDLE);
endmodule
